// File: rtl/pds_cycle_seq.sv
// pds_cycle_seq
//   Sequences a 68030 bus cycle aimed at the 68000 PDS into a correctly
//   phased 68000 address-strobe cycle. Actions are aligned to synchronized
//   C8M edges. The block latches the cycle direction, reports normal
//   termination to the glue stage, and requests a bus error when the SE
//   never terminates the cycle.
//
// Ports
//   cpuClock      in   primary clock; all state changes on its rising edge
//   pdsReset      in   asynchronous active-high reset
//   ncpuAs        in   68030 address strobe (active low)
//   cpuRnW        in   68030 read/write
//   cpuFC[2:0]    in   68030 function code (7 = CPU space, never forwarded)
//   pdsAddrSel    in   current address decodes to PDS space
//   pdsC8m        in   SE 8 MHz clock, asynchronous
//   npdsDtack     in   PDS DTACK (active low), asynchronous
//   cycle68Done   in   one-cycle pulse from the 6800 (VPA/VMA) termination logic
//   npdsAs        out  PDS address strobe value (active low)
//   pdsAsOe       out  tristate enable for npdsAs/npdsRnW
//   npdsRnW       out  latched PDS read/write
//   pdsTermPulse  out  one-cycle pulse on normal termination
//   busErrReq     out  bus-error request, held until the cycle recovers
//   cycleActive   out  high from ALIGN entry until the return to IDLE

module pds_cycle_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_C8M = 200,
  parameter int unsigned TMO_WIDTH   = 8
) (
  input  logic       cpuClock,
  input  logic       pdsReset,
  input  logic       ncpuAs,
  input  logic       cpuRnW,
  input  logic [2:0] cpuFC,
  input  logic       pdsAddrSel,
  input  logic       pdsC8m,
  input  logic       npdsDtack,
  input  logic       cycle68Done,
  output logic       npdsAs,
  output logic       pdsAsOe,
  output logic       npdsRnW,
  output logic       pdsTermPulse,
  output logic       busErrReq,
  output logic       cycleActive
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALIGN   = 3'd1,
    S_ASSERT  = 3'd2,
    S_TERM    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // Synchronizers and history flops
  logic [SYNC_STAGES-1:0] c8m_sync_q, c8m_sync_d;
  logic [SYNC_STAGES-1:0] dtack_sync_q, dtack_sync_d;
  logic                   c8m_hist_q, c8m_hist_d;
  logic                   dtack_hist_q, dtack_hist_d;

  logic c8m_cur;
  logic c8m_rise;
  logic c8m_fall;
  logic dtack_n_s;

  // Sequencer state
  state_t                 state_q, state_d;
  logic                   npds_as_q, npds_as_d;
  logic                   as_oe_q, as_oe_d;
  logic                   rnw_q, rnw_d;
  logic                   term_pulse_q, term_pulse_d;
  logic                   bus_err_q, bus_err_d;
  logic                   active_q, active_d;
  logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
  logic [TMO_WIDTH-1:0]   tmo_next;

  logic pds_request;
  logic term_ok;
  logic timeout_hit;

  // Synchronizer next-state
  always_comb begin
    c8m_sync_d   = {c8m_sync_q[SYNC_STAGES-2:0], pdsC8m};
    dtack_sync_d = {dtack_sync_q[SYNC_STAGES-2:0], npdsDtack};
    c8m_hist_d   = c8m_sync_q[SYNC_STAGES-1];
    dtack_hist_d = dtack_sync_q[SYNC_STAGES-1];
  end

  assign c8m_cur  = c8m_sync_q[SYNC_STAGES-1];
  assign c8m_rise = ~c8m_hist_q &  c8m_cur;
  assign c8m_fall =  c8m_hist_q & ~c8m_cur;
  // DTACK is taken from its history flop so that it has the same latency as
  // the C8M edge strobes that sample it.
  assign dtack_n_s = dtack_hist_q;

  always_ff @(posedge cpuClock or posedge pdsReset) begin
    if (pdsReset) begin
      c8m_sync_q   <= '1;
      dtack_sync_q <= '1;
      c8m_hist_q   <= 1'b1;
      dtack_hist_q <= 1'b1;
    end else begin
      c8m_sync_q   <= c8m_sync_d;
      dtack_sync_q <= dtack_sync_d;
      c8m_hist_q   <= c8m_hist_d;
      dtack_hist_q <= dtack_hist_d;
    end
  end

  // Cycle qualification and termination conditions
  assign pds_request = ~ncpuAs & pdsAddrSel & (cpuFC != 3'h7);
  assign term_ok     = (c8m_fall & ~dtack_n_s) | cycle68Done;
  assign tmo_next    = tmo_q + TMO_WIDTH'(1);
  assign timeout_hit = c8m_rise & (tmo_next == TMO_WIDTH'(TIMEOUT_C8M));

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    npds_as_d    = npds_as_q;
    as_oe_d      = as_oe_q;
    rnw_d        = rnw_q;
    term_pulse_d = 1'b0;
    bus_err_d    = bus_err_q;
    active_d     = active_q;
    tmo_d        = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (pds_request) begin
          state_d  = S_ALIGN;
          rnw_d    = cpuRnW;
          active_d = 1'b1;
        end
      end

      S_ALIGN: begin
        // A CPU that gives up before the C8M fall gets no PDS cycle at all;
        // the abort takes priority over a coincident fall.
        if (ncpuAs) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end else if (c8m_fall) begin
          state_d   = S_ASSERT;
          npds_as_d = 1'b0;
          as_oe_d   = 1'b1;
        end
      end

      S_ASSERT: begin
        if (c8m_rise) begin
          tmo_d = tmo_next;
        end
        // Termination beats a timeout landing on the same cycle; an abort
        // by the CPU suppresses any bus error.
        if (term_ok) begin
          state_d      = S_TERM;
          term_pulse_d = 1'b1;
        end else if (ncpuAs) begin
          state_d = S_TERM;
        end else if (timeout_hit) begin
          state_d   = S_TERM;
          bus_err_d = 1'b1;
        end
      end

      S_TERM: begin
        if (c8m_rise) begin
          state_d   = S_RECOVER;
          npds_as_d = 1'b1;
        end
      end

      S_RECOVER: begin
        as_oe_d = 1'b0;
        if (ncpuAs) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b0;
          tmo_d     = '0;
          active_d  = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        npds_as_d = 1'b1;
        as_oe_d   = 1'b0;
        rnw_d     = 1'b1;
        bus_err_d = 1'b0;
        active_d  = 1'b0;
        tmo_d     = '0;
      end
    endcase
  end

  always_ff @(posedge cpuClock or posedge pdsReset) begin
    if (pdsReset) begin
      state_q      <= S_IDLE;
      npds_as_q    <= 1'b1;
      as_oe_q      <= 1'b0;
      rnw_q        <= 1'b1;
      term_pulse_q <= 1'b0;
      bus_err_q    <= 1'b0;
      active_q     <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      npds_as_q    <= npds_as_d;
      as_oe_q      <= as_oe_d;
      rnw_q        <= rnw_d;
      term_pulse_q <= term_pulse_d;
      bus_err_q    <= bus_err_d;
      active_q     <= active_d;
      tmo_q        <= tmo_d;
    end
  end

  assign npdsAs       = npds_as_q;
  assign pdsAsOe      = as_oe_q;
  assign npdsRnW      = rnw_q;
  assign pdsTermPulse = term_pulse_q;
  assign busErrReq    = bus_err_q;
  assign cycleActive  = active_q;

endmodule

// File: tb/tb_pds_cycle_seq.sv
// tb_pds_cycle_seq
//   Directed bench for pds_cycle_seq. cpuClock has a 10 ns period and C8M is
//   cpuClock/4, offset so its edges never coincide with cpuClock edges.
//   Inputs are driven and outputs sampled on cpuClock falling edges; tick k
//   of a test is the k-th falling edge after the cycle is started.

module tb_pds_cycle_seq;

  logic       cpuClock    = 1'b0;
  logic       pdsReset    = 1'b1;
  logic       ncpuAs      = 1'b1;
  logic       cpuRnW      = 1'b1;
  logic [2:0] cpuFC       = 3'h5;
  logic       pdsAddrSel  = 1'b0;
  logic       pdsC8m      = 1'b1;
  logic       npdsDtack   = 1'b1;
  logic       cycle68Done = 1'b0;
  logic       npdsAs;
  logic       pdsAsOe;
  logic       npdsRnW;
  logic       pdsTermPulse;
  logic       busErrReq;
  logic       cycleActive;

  int n_tests    = 0;
  int n_fail     = 0;
  int pulse_cnt  = 0;
  int as_low_cnt = 0;

  pds_cycle_seq #(
    .SYNC_STAGES (2),
    .TIMEOUT_C8M (8),
    .TMO_WIDTH   (8)
  ) dut (
    .cpuClock     (cpuClock),
    .pdsReset     (pdsReset),
    .ncpuAs       (ncpuAs),
    .cpuRnW       (cpuRnW),
    .cpuFC        (cpuFC),
    .pdsAddrSel   (pdsAddrSel),
    .pdsC8m       (pdsC8m),
    .npdsDtack    (npdsDtack),
    .cycle68Done  (cycle68Done),
    .npdsAs       (npdsAs),
    .pdsAsOe      (pdsAsOe),
    .npdsRnW      (npdsRnW),
    .pdsTermPulse (pdsTermPulse),
    .busErrReq    (busErrReq),
    .cycleActive  (cycleActive)
  );

  always #5 cpuClock = ~cpuClock;

  // C8M falls at 40k+22 ns and rises at 40k+42 ns.
  initial begin
    #2;
    forever #20 pdsC8m = ~pdsC8m;
  end

  always @(negedge cpuClock) begin
    if (pdsTermPulse) pulse_cnt++;
    if (!npdsAs)      as_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge cpuClock);
  endtask

  // Lands on the cpuClock falling edge 8 ns after a raw C8M fall; the
  // synchronized fall is then acted on at the second rising edge after it.
  task automatic sync_c8m();
    @(negedge pdsC8m);
    @(negedge cpuClock);
  endtask

  task automatic start_cycle(input logic [2:0] fc, input logic sel, input logic rnw);
    cpuFC      = fc;
    pdsAddrSel = sel;
    cpuRnW     = rnw;
    ncpuAs     = 1'b0;
  endtask

  task automatic run_write(input string pfx);
    int p0;
    p0 = pulse_cnt;
    sync_c8m();
    start_cycle(3'h5, 1'b1, 1'b0);
    tick(1);
    check({pfx, "_wr_active"}, 32'(cycleActive), 32'd1);
    check({pfx, "_wr_as_align"}, 32'(npdsAs), 32'd1);
    check({pfx, "_wr_rnw"}, 32'(npdsRnW), 32'd0);
    tick(1);
    check({pfx, "_wr_as_low"}, 32'(npdsAs), 32'd0);
    check({pfx, "_wr_oe_on"}, 32'(pdsAsOe), 32'd1);
    tick(4);
    npdsDtack = 1'b0;
    tick(3);
    check({pfx, "_wr_no_early_pulse"}, 32'(pdsTermPulse), 32'd0);
    tick(1);
    check({pfx, "_wr_pulse"}, 32'(pdsTermPulse), 32'd1);
    tick(1);
    check({pfx, "_wr_pulse_end"}, 32'(pdsTermPulse), 32'd0);
    check({pfx, "_wr_as_held_term"}, 32'(npdsAs), 32'd0);
    tick(1);
    check({pfx, "_wr_as_release"}, 32'(npdsAs), 32'd1);
    check({pfx, "_wr_oe_held"}, 32'(pdsAsOe), 32'd1);
    tick(1);
    check({pfx, "_wr_oe_off"}, 32'(pdsAsOe), 32'd0);
    check({pfx, "_wr_active_recover"}, 32'(cycleActive), 32'd1);
    ncpuAs    = 1'b1;
    npdsDtack = 1'b1;
    tick(1);
    check({pfx, "_wr_idle"}, 32'(cycleActive), 32'd0);
    tick(2);
    check({pfx, "_wr_pulse_count"}, 32'(pulse_cnt - p0), 32'd1);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_as", 32'(npdsAs), 32'd1);
    check("rst_oe", 32'(pdsAsOe), 32'd0);
    check("rst_rnw", 32'(npdsRnW), 32'd1);
    check("rst_pulse", 32'(pdsTermPulse), 32'd0);
    check("rst_berr", 32'(busErrReq), 32'd0);
    check("rst_active", 32'(cycleActive), 32'd0);
    pdsReset = 1'b0;
    tick(3);

    // Write cycle terminated by DTACK
    run_write("a");

    // Timeout: DTACK stays high; 8th synchronized C8M rise in ASSERT is at tick 32
    begin
      int p0;
      p0 = pulse_cnt;
      sync_c8m();
      start_cycle(3'h5, 1'b1, 1'b1);
      tick(2);
      check("to_as_low", 32'(npdsAs), 32'd0);
      check("to_rnw", 32'(npdsRnW), 32'd1);
      tick(29);
      check("to_berr_early", 32'(busErrReq), 32'd0);
      tick(1);
      check("to_berr_set", 32'(busErrReq), 32'd1);
      check("to_as_still_low", 32'(npdsAs), 32'd0);
      tick(3);
      check("to_as_held", 32'(npdsAs), 32'd0);
      tick(1);
      check("to_as_release", 32'(npdsAs), 32'd1);
      check("to_oe_held", 32'(pdsAsOe), 32'd1);
      tick(1);
      check("to_oe_off", 32'(pdsAsOe), 32'd0);
      check("to_berr_hold", 32'(busErrReq), 32'd1);
      tick(1);
      check("to_berr_hold2", 32'(busErrReq), 32'd1);
      ncpuAs = 1'b1;
      tick(1);
      check("to_berr_clear", 32'(busErrReq), 32'd0);
      check("to_idle", 32'(cycleActive), 32'd0);
      check("to_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    end

    // CPU-space and non-PDS cycles are ignored
    start_cycle(3'h7, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("fc7_quiet", 32'({cycleActive, npdsAs, pdsAsOe}), 32'b010);
    end
    start_cycle(3'h5, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("nonpds_quiet", 32'({cycleActive, npdsAs, pdsAsOe}), 32'b010);
    end
    ncpuAs = 1'b1;
    tick(2);

    // Abort in ALIGN, well clear of the next synchronized C8M fall
    begin
      int p0;
      int a0;
      p0 = pulse_cnt;
      a0 = as_low_cnt;
      sync_c8m();
      tick(2);
      start_cycle(3'h5, 1'b1, 1'b0);
      tick(1);
      check("ab_active", 32'(cycleActive), 32'd1);
      ncpuAs = 1'b1;
      tick(1);
      check("ab_idle", 32'(cycleActive), 32'd0);
      tick(6);
      check("ab_as_never_low", 32'(as_low_cnt - a0), 32'd0);
      check("ab_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      check("ab_oe_off", 32'(pdsAsOe), 32'd0);
    end

    // VPA termination on the same cycle the timeout would fire
    begin
      int p0;
      p0 = pulse_cnt;
      sync_c8m();
      start_cycle(3'h5, 1'b1, 1'b1);
      tick(2);
      check("vpa_as_low", 32'(npdsAs), 32'd0);
      tick(29);
      cycle68Done = 1'b1;
      tick(1);
      cycle68Done = 1'b0;
      check("vpa_pulse", 32'(pdsTermPulse), 32'd1);
      check("vpa_no_berr", 32'(busErrReq), 32'd0);
      tick(1);
      check("vpa_pulse_end", 32'(pdsTermPulse), 32'd0);
      check("vpa_no_berr2", 32'(busErrReq), 32'd0);
      tick(3);
      check("vpa_as_release", 32'(npdsAs), 32'd1);
      tick(1);
      ncpuAs = 1'b1;
      tick(1);
      check("vpa_idle", 32'(cycleActive), 32'd0);
      check("vpa_berr_final", 32'(busErrReq), 32'd0);
      check("vpa_pulse_count", 32'(pulse_cnt - p0), 32'd1);
    end

    // Asynchronous reset while in ASSERT
    sync_c8m();
    start_cycle(3'h5, 1'b1, 1'b0);
    tick(4);
    check("rs_as_low", 32'(npdsAs), 32'd0);
    #3;
    pdsReset = 1'b1;
    #1;
    check("rs_as", 32'(npdsAs), 32'd1);
    check("rs_oe", 32'(pdsAsOe), 32'd0);
    check("rs_berr", 32'(busErrReq), 32'd0);
    check("rs_active", 32'(cycleActive), 32'd0);
    ncpuAs = 1'b1;
    @(negedge cpuClock);
    pdsReset = 1'b0;
    tick(2);
    check("rs_idle", 32'(cycleActive), 32'd0);
    check("rs_as_idle", 32'(npdsAs), 32'd1);
    tick(2);

    // A fresh cycle after reset behaves normally
    run_write("b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
